seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Generates the 2-bit digit select that steers the upstream 4:1 nibble mux (mux4x1 `s`).
- Consumes the mux's 4-bit output, decodes it to segments, and drives registered anode/segment/dp pins with an anti-ghosting blank window at every digit switch.

Parameters:
- DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range ≥ 2.
- BLANK_CYC, 4: cycles at the start of each slot during which all anodes are off; legal range 0 ≤ BLANK_CYC < DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; 0 freezes the scan and blanks the display.
- digit_in  in  4  hex nibble for the currently selected digit (from mux4x1 `out`).
- dp_in  in  4  per-digit decimal point, active-high; bit i belongs to digit i.
- digit_sel  out  2  digit index; drives mux4x1 `s`.
- anode  out  4  active-low digit enables; bit i is digit i.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse once per full 4-digit frame.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values (applied immediately, no clock needed): cnt=0, digit_sel=0, anode=4'hF, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler: cnt counts 0..DIV-1, advancing only when en=1.
  - At cnt==DIV-1 with en=1: cnt→0 and digit_sel→digit_sel+1, wrapping 3→0.
  - digit_sel is driven directly from its register, so it is stable for a whole slot.
- Mux path: the upstream mux is combinational, so digit_in is valid in the same cycle as digit_sel.
- Output registers: every edge samples the current cnt, digit_sel, digit_in and dp_in, so all pin outputs lag by exactly 1 cycle.
  - If en=1 and cnt ≥ BLANK_CYC: anode ← ~(1<<digit_sel), seg ← decode(digit_in), dp ← ~dp_in[digit_sel].
  - Otherwise: anode ← 4'hF, seg ← 7'h7F, dp ← 1.
- Decode table (active-low, digit 0..F): 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- frame_tick: registered pulse, high for 1 cycle after an edge where en=1, cnt==DIV-1 and digit_sel==3.
- en=0:
  - cnt and digit_sel hold their values.
  - Outputs blank starting the next cycle.
  - When en returns to 1, the scan resumes from the held cnt and digit_sel; nothing is restarted.
- Reset mid-slot: takes effect immediately; after release, the scan restarts at digit 0, cnt 0.
- digit_in changing mid-slot: the new glyph appears on seg the next cycle; no glitch filtering is applied.
- BLANK_CYC=0: no blank window; the anode changes exactly 1 cycle after digit_sel changes.
- Widths: cnt width is $clog2(DIV), computed as a localparam; cnt never exceeds DIV-1.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK=7'h7F and ANODE_OFF=4'hF.
  - The 16-entry decode constant/function.
  - The digit count (4).
- Sub-module hex_to_7seg: combinational nibble→seg decoder, reused by other display logic.
- Prescaler, select counter, blanking and output registers stay in seg7_scan_driver.

Test Plan (DIV=8, BLANK_CYC=2, digit i fed by mux in_i):
- Async reset: assert rst between clock edges mid-slot → anode=F, seg=7F, dp=1, digit_sel=0 immediately.
  - After release, the first anode=E appears 3 cycles later (2 blank cycles + 1 register cycle).
- Scan: en=1 with mux inputs 1,2,3,4.
  - digit_sel steps 0,1,2,3 every 8 cycles.
  - Each slot: anode F for 2 cycles, then E/D/B/7 for 6 cycles, with seg 79, 24, 30, 19 respectively.
- Decode sweep: hold digit_sel=0 and force digit_in 0..F during the visible window → seg follows the full table (40…0E), 1 cycle later.
- Enable gap: drop en at cnt=5 for 10 cycles.
  - Outputs go F/7F/1 the next cycle; digit_sel and cnt hold.
  - On re-enable, the current slot completes from cnt=5: 3 more cycles before the digit advances.
- frame_tick: exactly one 1-cycle pulse every 32 enabled cycles, in the cycle after digit_sel wraps 3→0; no pulse while en=0.
- Decimal point: dp_in=4'b0100 → dp=0 only in cycles where anode=4'b1011, otherwise 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and glyph table for the 4-digit common-anode display path.
package seg7_pkg;

  // Number of multiplexed digits and the width of the digit index.
  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = $clog2(NUM_DIGITS);

  typedef logic [SEL_W-1:0]      digit_idx_t;
  typedef logic [NUM_DIGITS-1:0] anode_t;
  typedef logic [6:0]            seg_t;

  // All outputs are active-low, so "off" is all ones.
  localparam seg_t   SEG_BLANK = 7'h7F;
  localparam anode_t ANODE_OFF = 4'hF;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Nibble to active-low segment pattern.
  function automatic seg_t seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; no registering so callers choose their own timing.
  always_comb begin
    seg_o = seg_decode(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode display.
// A prescaler divides each digit slot into DIV cycles; the first BLANK_CYC
// cycles of each slot keep all anodes off so the previous glyph cannot ghost
// onto the next digit. All pin outputs are registered and lag the scan state
// by one cycle. digit_sel comes straight from its register so the upstream
// combinational nibble mux sees a select that is stable for the whole slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_in,
  input  logic [3:0] dp_in,
  output logic [1:0] digit_sel,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    sel_q, sel_d;
  anode_t        anode_q, anode_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;

  logic          slot_end;
  logic          past_blank;
  seg_t          glyph;

  hex_to_7seg u_dec (
    .nibble_i (digit_in),
    .seg_o    (glyph)
  );

  assign slot_end = (cnt_q == CNT_LAST);

  // With no blank window every cycle of the slot is visible; elaborating the
  // compare away avoids an always-true unsigned comparison.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign past_blank = 1'b1;
    end else begin : g_blank
      assign past_blank = (cnt_q >= CNT_BLANK);
    end
  endgenerate

  // Prescaler and digit select: both freeze while en is low.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        sel_d = sel_q + digit_idx_t'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Pin values for the next cycle: lit only when enabled and past the blank window.
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    tick_d  = en && slot_end && (sel_q == LAST_DIGIT);
    if (en && past_blank) begin
      anode_d = ~(anode_t'(1) << sel_q);
      seg_d   = glyph;
      dp_d    = ~dp_in[sel_q];
    end
  end

  // Scan state and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  assign digit_sel  = sel_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
